// File: rtl/dyser_out_fifo_if.sv
// Handshake bundle between the upstream ff_stage, dyser_out_fifo and the output-port consumer.
// Latency: none; this is wiring only.
// Backpressure: upstream is paced by credit_out, and the consumer pops with ready_in.
// Ports: valid_in/data_in/credit_out face the upstream stage; valid_out/data_out/ready_in face the consumer.
`ifndef PATH_WIDTH
`define PATH_WIDTH 32
`endif

interface dyser_out_fifo_if #(
  parameter int W = `PATH_WIDTH
);
  logic         valid_in;
  logic [W-1:0] data_in;
  logic         credit_out;
  logic         valid_out;
  logic [W-1:0] data_out;
  logic         ready_in;

  // The buffer itself
  modport slave (
    input  valid_in,
    input  data_in,
    input  ready_in,
    output credit_out,
    output valid_out,
    output data_out
  );

  // The environment: upstream stage and consumer together
  modport master (
    output valid_in,
    output data_in,
    output ready_in,
    input  credit_out,
    input  valid_out,
    input  data_out
  );
endinterface

// File: rtl/dyser_out_fifo.sv
// Credit-based DEPTH-entry output buffer behind a DySER ff_stage, with show-ahead valid/ready output.
// Latency: a push is visible on valid_out/data_out the next cycle (no bypass); the credit returns one cycle after the push, or one cycle after the freeing pop.
// Backpressure: one credit is outstanding at most. A push without a credit, or into a full buffer with no pop, is dropped and raises sticky err_overflow.
// Ports: clk, rst (async active-low), bus (slave modport: valid_in, data_in, credit_out, valid_out, data_out, ready_in), count (occupancy), err_overflow.
`ifndef PATH_WIDTH
`define PATH_WIDTH 32
`endif

module dyser_out_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic               clk,
  input  logic               rst,
  dyser_out_fifo_if.slave    bus,
  output logic [AW:0]        count,
  output logic               err_overflow
);

  logic [`PATH_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          holds;
  logic          credit_q;

  logic          pop;
  logic          full;
  logic          ovf;
  logic          push;
  logic          h;
  logic          issue;
  logic [AW:0]   count_nxt;
  logic [AW-1:0] wr_ptr_inc;
  logic [AW-1:0] rd_ptr_inc;

  always_comb begin
    pop       = (count != '0) & bus.ready_in;
    full      = (count == (AW+1)'(DEPTH));
    // A push is illegal if the upstream holds no credit. It is also illegal if it would
    // overrun a full buffer that is not popping this cycle.
    ovf       = bus.valid_in & (~holds | (full & ~pop));
    push      = bus.valid_in & ~ovf;
    count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
    // A legal push consumes the upstream's credit. A new credit goes out only
    // when none is held and a slot remains free beyond what is already stored.
    // This keeps count + holds <= DEPTH.
    h         = holds & ~push;
    issue     = ~h & (count_nxt < (AW+1)'(DEPTH));
    wr_ptr_inc = (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
    rd_ptr_inc = (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      holds        <= 1'b1;   // upstream leaves reset already owning one credit
      credit_q     <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      count    <= count_nxt;
      holds    <= h | issue;
      credit_q <= issue;
      if (push) begin
        wr_ptr <= wr_ptr_inc;
      end
      if (pop) begin
        rd_ptr <= rd_ptr_inc;
      end
      if (ovf) begin
        err_overflow <= 1'b1;
      end
    end
  end

  // Storage has no reset, so its contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  assign bus.credit_out = credit_q;
  assign bus.valid_out  = (count != '0);
  assign bus.data_out   = mem[rd_ptr];

endmodule

// File: tb/tb_dyser_out_fifo.sv
// Self-checking bench for dyser_out_fifo. It runs directed stimulus against a queue-based reference model.
// Latency: outputs are compared every negedge against the model, plus hand-computed literal checks.
// Backpressure: the bench plays a single-credit upstream and a ready_in-driven consumer.
`ifndef PATH_WIDTH
`define PATH_WIDTH 32
`endif

module tb_dyser_out_fifo;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int W     = `PATH_WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW:0]   count;
  logic          err_overflow;

  int errors = 0;
  int checks = 0;

  dyser_out_fifo_if #(.W(W)) bus();

  dyser_out_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .count        (count),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model. It holds the buffered data as a queue, whether the upstream owns a
  // credit, the credit pulse expected this cycle, and the sticky error.
  logic [W-1:0] mq[$];
  bit           m_holds  = 1'b1;
  bit           m_credit = 1'b0;
  bit           m_err    = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_holds  <= 1'b1;
      m_credit <= 1'b0;
      m_err    <= 1'b0;
    end else begin : model_step
      bit pop_now;
      bit take;
      bit hold_left;
      pop_now = bus.ready_in && (mq.size() != 0);
      take    = bus.valid_in && m_holds && !((mq.size() == DEPTH) && !pop_now);
      if (bus.valid_in && !take) m_err <= 1'b1;
      if (pop_now) void'(mq.pop_front());
      if (take) mq.push_back(bus.data_in);
      hold_left = m_holds && !take;
      // Send a credit whenever the upstream has none and a slot is free.
      if (!hold_left && (mq.size() < DEPTH)) begin
        m_credit <= 1'b1;
        m_holds  <= 1'b1;
      end else begin
        m_credit <= 1'b0;
        m_holds  <= hold_left;
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_count",  32'(count), 32'(mq.size()));
    chk("cmp_valid",  32'(bus.valid_out), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("cmp_data", 32'(bus.data_out), 32'(mq[0]));
    chk("cmp_credit", 32'(bus.credit_out), 32'(m_credit));
    chk("cmp_err",    32'(err_overflow), 32'(m_err));
    chk("cmp_bound",  32'(count <= DEPTH), 32'd1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [W-1:0] d);
    bus.valid_in = 1'b1;
    bus.data_in  = d;
    step();
    bus.valid_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    bus.ready_in = 1'b0;

    // Reset and idle
    repeat (3) step();
    chk("rst_count",  32'(count), 32'd0);
    chk("rst_valid",  32'(bus.valid_out), 32'd0);
    chk("rst_credit", 32'(bus.credit_out), 32'd0);
    chk("rst_err",    32'(err_overflow), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_credit", 32'(bus.credit_out), 32'd0);
      chk("idle_valid",  32'(bus.valid_out), 32'd0);
    end

    // Single transfer
    push1(32'h0000_00A5);
    chk("sgl_credit", 32'(bus.credit_out), 32'd1);
    chk("sgl_valid",  32'(bus.valid_out), 32'd1);
    chk("sgl_data",   32'(bus.data_out), 32'hA5);
    chk("sgl_count",  32'(count), 32'd1);
    step();
    chk("sgl_credit_once", 32'(bus.credit_out), 32'd0);
    chk("sgl_data_hold",   32'(bus.data_out), 32'hA5);
    bus.ready_in = 1'b1;
    step();
    bus.ready_in = 1'b0;
    chk("sgl_pop_count",  32'(count), 32'd0);
    chk("sgl_pop_credit", 32'(bus.credit_out), 32'd0);
    step();

    // Fill and stall
    for (int i = 1; i <= 4; i++) begin
      push1(W'(i));
      chk("fill_credit", 32'(bus.credit_out), (i < 4) ? 32'd1 : 32'd0);
      step();
    end
    chk("fill_count", 32'(count), 32'd4);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_credit", 32'(bus.credit_out), 32'd0);
    end
    chk("stall_head", 32'(bus.data_out), 32'd1);
    bus.ready_in = 1'b1;
    step();
    bus.ready_in = 1'b0;
    chk("unstall_credit", 32'(bus.credit_out), 32'd1);
    chk("unstall_count",  32'(count), 32'd3);
    chk("unstall_head",   32'(bus.data_out), 32'd2);
    bus.ready_in = 1'b1;
    repeat (3) step();
    bus.ready_in = 1'b0;
    chk("drain_count", 32'(count), 32'd0);

    // Simultaneous push and pop at count=2
    push1(W'(7));
    step();
    push1(W'(8));
    step();
    chk("sim_pre_count", 32'(count), 32'd2);
    chk("sim_pre_head",  32'(bus.data_out), 32'd7);
    bus.valid_in = 1'b1;
    bus.data_in  = W'(9);
    bus.ready_in = 1'b1;
    step();
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b0;
    chk("sim_count",  32'(count), 32'd2);
    chk("sim_head",   32'(bus.data_out), 32'd8);
    chk("sim_credit", 32'(bus.credit_out), 32'd1);
    bus.ready_in = 1'b1;
    step();
    chk("sim_tail", 32'(bus.data_out), 32'd9);
    step();
    chk("sim_empty", 32'(count), 32'd0);

    // Pointer wrap with a continuously ready consumer
    for (int i = 0; i < 10; i++) begin
      push1(W'(100 + i));
      chk("wrap_data",  32'(bus.data_out), 32'(100 + i));
      chk("wrap_count", 32'(count), 32'd1);
      step();
      chk("wrap_drain", 32'(count), 32'd0);
    end
    bus.ready_in = 1'b0;

    // Protocol error, then reset mid-stream
    for (int i = 0; i < 4; i++) begin
      push1(W'(32'h11 + i));
      step();
    end
    push1(W'(32'h99));
    chk("ovf_err",    32'(err_overflow), 32'd1);
    chk("ovf_count",  32'(count), 32'd4);
    chk("ovf_head",   32'(bus.data_out), 32'h11);
    chk("ovf_credit", 32'(bus.credit_out), 32'd0);
    bus.ready_in = 1'b1;
    step();
    bus.ready_in = 1'b0;
    chk("ovf_pop_credit", 32'(bus.credit_out), 32'd1);
    chk("ovf_sticky",     32'(err_overflow), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_count",  32'(count), 32'd0);
    chk("arst_valid",  32'(bus.valid_out), 32'd0);
    chk("arst_credit", 32'(bus.credit_out), 32'd0);
    chk("arst_err",    32'(err_overflow), 32'd0);
    step();
    step();
    rst = 1'b1;
    step();
    chk("post_rst_credit", 32'(bus.credit_out), 32'd0);
    push1(W'(32'h55));
    chk("post_rst_push_credit", 32'(bus.credit_out), 32'd1);
    chk("post_rst_push_count",  32'(count), 32'd1);
    chk("post_rst_push_data",   32'(bus.data_out), 32'h55);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
